// File: rtl/hero_anim_sequencer.sv
// Hero sprite animation sequencer: idle/run/jump motion state, run-cycle stepping
// on video-frame ticks, and the registered ROM base address of the selected frame.
module hero_anim_sequencer #(
  parameter int unsigned FRAME_W        = 40,
  parameter int unsigned FRAME_H        = 66,
  parameter int unsigned NUM_RUN_FRAMES = 3,
  parameter int unsigned TICKS_PER_STEP = 6,
  parameter int unsigned JUMP_TICKS     = 30,
  parameter int unsigned ADDR_W         = 15
) (
  input  logic              i_vga_clk,
  input  logic              i_reset_n,
  input  logic              i_vsync,
  input  logic              i_run_left,
  input  logic              i_run_right,
  input  logic              i_jump,
  output logic [1:0]        o_anim_state,
  output logic [2:0]        o_frame_sel,
  output logic              o_facing_left,
  output logic              o_frame_changed,
  output logic [ADDR_W-1:0] o_rom_base
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;

  localparam int unsigned DIV_W  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int unsigned JCNT_W = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
  localparam int unsigned FRAME_SIZE = FRAME_W * FRAME_H;

  localparam logic [2:0]        FS_IDLE  = 3'd0;
  localparam logic [2:0]        FS_RUN1  = 3'd1;
  localparam logic [2:0]        FS_LAST  = 3'(NUM_RUN_FRAMES);
  localparam logic [2:0]        FS_JUMP  = 3'(NUM_RUN_FRAMES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICKS_PER_STEP - 1);
  localparam logic [JCNT_W-1:0] JCNT_LAST = JCNT_W'(JUMP_TICKS - 1);

  logic              r_vs_d;
  logic [1:0]        r_state;
  logic [2:0]        r_frame_sel;
  logic [2:0]        r_frame_prev;
  logic [DIV_W-1:0]  r_div;
  logic [JCNT_W-1:0] r_jcnt;
  logic              r_facing;
  logic              r_frame_changed;
  logic [ADDR_W-1:0] r_rom_base;

  logic              w_tick;
  logic              w_dir_valid;
  logic [1:0]        w_state_d;
  logic [2:0]        w_frame_d;
  logic [DIV_W-1:0]  w_div_d;
  logic [JCNT_W-1:0] w_jcnt_d;
  logic              w_facing_d;
  logic [ADDR_W-1:0] w_rom_base_d;

  // vsync is active low, so its falling edge marks the start of a video frame
  assign w_tick      = r_vs_d & ~i_vsync;
  assign w_dir_valid = i_run_left ^ i_run_right;

  always_comb begin
    w_state_d  = r_state;
    w_frame_d  = r_frame_sel;
    w_div_d    = r_div;
    w_jcnt_d   = r_jcnt;
    w_facing_d = r_facing;
    if (w_tick) begin
      if (w_dir_valid) begin
        w_facing_d = i_run_left;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_jump) begin
            w_state_d = ST_JUMP;
            w_jcnt_d  = '0;
            w_frame_d = FS_JUMP;
          end else if (w_dir_valid) begin
            w_state_d = ST_RUN;
            w_frame_d = FS_RUN1;
            w_div_d   = '0;
          end else begin
            w_frame_d = FS_IDLE;
          end
        end
        ST_RUN: begin
          if (i_jump) begin
            w_state_d = ST_JUMP;
            w_jcnt_d  = '0;
            w_frame_d = FS_JUMP;
          end else if (!w_dir_valid) begin
            w_state_d = ST_IDLE;
            w_frame_d = FS_IDLE;
          end else if (r_div == DIV_LAST) begin
            w_div_d   = '0;
            w_frame_d = (r_frame_sel == FS_LAST) ? FS_RUN1 : r_frame_sel + 3'd1;
          end else begin
            w_div_d = r_div + DIV_W'(1);
          end
        end
        ST_JUMP: begin
          if (r_jcnt == JCNT_LAST) begin
            if (w_dir_valid) begin
              w_state_d = ST_RUN;
              w_frame_d = FS_RUN1;
              w_div_d   = '0;
            end else begin
              w_state_d = ST_IDLE;
              w_frame_d = FS_IDLE;
            end
          end else begin
            w_jcnt_d = r_jcnt + JCNT_W'(1);
          end
        end
        default: begin
          w_state_d = ST_IDLE;
          w_frame_d = FS_IDLE;
        end
      endcase
    end
  end

  assign w_rom_base_d = ADDR_W'(r_frame_sel) * ADDR_W'(FRAME_SIZE);

  always_ff @(posedge i_vga_clk) begin
    if (!i_reset_n) begin
      r_vs_d          <= 1'b1;
      r_state         <= ST_IDLE;
      r_frame_sel     <= FS_IDLE;
      r_frame_prev    <= FS_IDLE;
      r_div           <= '0;
      r_jcnt          <= '0;
      r_facing        <= 1'b0;
      r_frame_changed <= 1'b0;
      r_rom_base      <= '0;
    end else begin
      r_vs_d          <= i_vsync;
      r_state         <= w_state_d;
      r_frame_sel     <= w_frame_d;
      r_div           <= w_div_d;
      r_jcnt          <= w_jcnt_d;
      r_facing        <= w_facing_d;
      // Pulse and base address both trail frame_sel by one cycle so they align
      r_frame_prev    <= r_frame_sel;
      r_frame_changed <= (r_frame_sel != r_frame_prev);
      r_rom_base      <= w_rom_base_d;
    end
  end

  assign o_anim_state    = r_state;
  assign o_frame_sel     = r_frame_sel;
  assign o_facing_left   = r_facing;
  assign o_frame_changed = r_frame_changed;
  assign o_rom_base      = r_rom_base;

endmodule

// File: tb/tb_hero_anim_sequencer.sv
// Directed self-checking bench for hero_anim_sequencer with hand-computed expectations.
module tb_hero_anim_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b1;
  logic        run_left = 1'b0;
  logic        run_right = 1'b0;
  logic        jump = 1'b0;
  logic [1:0]  anim_state;
  logic [2:0]  frame_sel;
  logic        facing_left;
  logic        frame_changed;
  logic [14:0] rom_base;

  int n_total = 0;
  int n_bad   = 0;

  hero_anim_sequencer u_dut (
    .i_vga_clk      (clk),
    .i_reset_n      (reset_n),
    .i_vsync        (vsync),
    .i_run_left     (run_left),
    .i_run_right    (run_right),
    .i_jump         (jump),
    .o_anim_state   (anim_state),
    .o_frame_sel    (frame_sel),
    .o_facing_left  (facing_left),
    .o_frame_changed(frame_changed),
    .o_rom_base     (rom_base)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One vsync low pulse; returns once frame_changed/rom_base for this tick are visible
  task automatic do_tick();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"}, 32'(anim_state), 32'd0);
    check_val({tag, "_frame"}, 32'(frame_sel), 32'd0);
    check_val({tag, "_facing"}, 32'(facing_left), 32'd0);
    check_val({tag, "_fchg"}, 32'(frame_changed), 32'd0);
    check_val({tag, "_rom"}, 32'(rom_base), 32'd0);
  endtask

  initial begin
    int exp_f;
    int fc_cnt;

    // 1: reset, idle ticks
    @(negedge clk);
    apply_reset();
    check_reset_vals("rst");
    for (int t = 0; t < 3; t++) do_tick();
    check_val("idle_state", 32'(anim_state), 32'd0);
    check_val("idle_frame", 32'(frame_sel), 32'd0);
    check_val("idle_rom", 32'(rom_base), 32'd0);

    // 2: run right for 20 ticks
    run_right = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      do_tick();
      exp_f = ((t - 1) / 6) % 3 + 1;
      check_val($sformatf("run_frame_t%0d", t), 32'(frame_sel), 32'(exp_f));
      check_val($sformatf("run_fchg_t%0d", t), 32'(frame_changed),
                ((t - 1) % 6 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("run_rom_t%0d", t), 32'(rom_base), 32'(exp_f * 2640));
    end
    check_val("run_state", 32'(anim_state), 32'd1);
    check_val("run_facing", 32'(facing_left), 32'd0);

    // 3: run left, then both pressed
    run_right = 1'b0;
    apply_reset();
    run_left = 1'b1;
    do_tick();
    check_val("left_state", 32'(anim_state), 32'd1);
    check_val("left_facing", 32'(facing_left), 32'd1);
    run_right = 1'b1;
    do_tick();
    check_val("both_state", 32'(anim_state), 32'd0);
    check_val("both_frame", 32'(frame_sel), 32'd0);
    check_val("both_facing", 32'(facing_left), 32'd1);
    run_left  = 1'b0;
    run_right = 1'b0;

    // 4: jump from run, re-press ignored, exit after 30 ticks
    apply_reset();
    run_right = 1'b1;
    do_tick();
    check_val("pre_jump_state", 32'(anim_state), 32'd1);
    jump = 1'b1;
    do_tick();
    check_val("jump_state", 32'(anim_state), 32'd2);
    check_val("jump_frame", 32'(frame_sel), 32'd4);
    check_val("jump_rom", 32'(rom_base), 32'd10560);
    for (int k = 1; k <= 30; k++) begin
      jump = k[0];
      if (k == 10) begin
        run_left  = 1'b1;
        run_right = 1'b0;
      end else begin
        run_left  = 1'b0;
        run_right = 1'b1;
      end
      do_tick();
      if (k == 10) check_val("jump_facing_l", 32'(facing_left), 32'd1);
      if (k == 11) check_val("jump_facing_r", 32'(facing_left), 32'd0);
      if (k == 29) begin
        check_val("jump_hold_state", 32'(anim_state), 32'd2);
        check_val("jump_hold_frame", 32'(frame_sel), 32'd4);
      end
    end
    check_val("jump_exit_state", 32'(anim_state), 32'd1);
    check_val("jump_exit_frame", 32'(frame_sel), 32'd1);
    check_val("jump_exit_rom", 32'(rom_base), 32'd2640);
    jump = 1'b0;

    // 5: reset mid-jump
    jump = 1'b1;
    do_tick();
    jump = 1'b0;
    do_tick();
    check_val("mid_jump_state", 32'(anim_state), 32'd2);
    run_right = 1'b0;
    apply_reset();
    check_reset_vals("rst_jump");
    do_tick();
    check_val("post_rst_state", 32'(anim_state), 32'd0);
    check_val("post_rst_frame", 32'(frame_sel), 32'd0);

    // 6: vsync held low => single tick; controls toggled between ticks
    run_right = 1'b1;
    fc_cnt = 0;
    @(negedge clk) vsync = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (frame_changed) fc_cnt++;
    end
    check_val("hold_state", 32'(anim_state), 32'd1);
    check_val("hold_frame", 32'(frame_sel), 32'd1);
    check_val("hold_fchg_cnt", 32'(fc_cnt), 32'd1);
    @(negedge clk) vsync = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      run_left = c[0];
      jump     = c[1];
    end
    @(negedge clk);
    check_val("between_state", 32'(anim_state), 32'd1);
    check_val("between_frame", 32'(frame_sel), 32'd1);
    check_val("between_facing", 32'(facing_left), 32'd0);
    check_val("between_fchg", 32'(frame_changed), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
